// File: rtl/mult_div_unit_if.sv
// Bus between the control path and the multiply/divide unit:
// operation request, MTHI/MTLO writes, status pulses and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in,
        output mthi, mtlo, hi_wdata, lo_wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        input  mthi, mtlo, hi_wdata, lo_wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per clock.
// Works on magnitudes and fixes signs in the final state.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic             divop_q, divop_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             sgn;
    logic [WIDTH-1:0] amag;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Datapath helpers: operand magnitudes, one iteration step, sign fix
    always_comb begin
        sgn = ~bus.op[0];
        amag = (sgn && bus.a_in[WIDTH-1]) ? ('0 - bus.a_in) : bus.a_in;
        bmag = (sgn && bus.b_in[WIDTH-1]) ? ('0 - bus.b_in) : bus.b_in;
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                + (p_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_shift - {1'b0, opnd_q};
        prod_fix = neg_q ? ('0 - p_q) : p_q;
        quot_fix = neg_q ? ('0 - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        rem_fix = rneg_q ? ('0 - p_q[2*WIDTH-1:WIDTH])
                         : p_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM next state plus register updates
    always_comb begin
        state_d = state_q;
        divop_d = divop_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        dz_d = dz_q;
        cnt_d = cnt_q;
        opnd_d = opnd_q;
        p_d = p_q;
        hi_d = hi_q;
        lo_d = lo_q;
        done_d = 1'b0;
        divz_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    divop_d = bus.op[1];
                    neg_d = sgn & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                    rneg_d = sgn & bus.a_in[WIDTH-1];
                    dz_d = bus.op[1] && (bus.b_in == '0);
                    cnt_d = CW'(WIDTH);
                    // Multiply: |b| shifts out of the low half, |a| is added.
                    // Divide: |a| shifts into the remainder, |b| is subtracted.
                    opnd_d = bus.op[1] ? bmag : amag;
                    p_d = {{WIDTH{1'b0}}, bus.op[1] ? amag : bmag};
                    state_d = (bus.op[1] && (bus.b_in == '0)) ? FIX : CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.hi_wdata;
                    if (bus.mtlo) lo_d = bus.lo_wdata;
                end
            end
            CALC: begin
                if (divop_q) begin
                    if (!div_diff[WIDTH]) begin
                        p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                done_d = 1'b1;
                divz_d = dz_q;
                if (!dz_q) begin
                    if (divop_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            divop_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q <= 1'b0;
            cnt_q <= '0;
            opnd_q <= '0;
            p_q <= '0;
            done_q <= 1'b0;
            divz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            state_q <= state_d;
            divop_q <= divop_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            dz_q <= dz_d;
            cnt_q <= cnt_d;
            opnd_q <= opnd_d;
            p_q <= p_d;
            done_q <= done_d;
            divz_q <= divz_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.div_zero = divz_q;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed operations, expected results
// queued at issue time and checked by a monitor on each done pulse.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q[$];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", bus.hi, e.hi);
                chk("lo", bus.lo, e.lo);
                chk("div_zero", {31'b0, bus.div_zero}, {31'b0, e.dz});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz,
                          input bit poke, input bit mt);
        exp_t e;
        int nb;
        bit fin;
        @(negedge clk);
        bus.op = op;
        bus.a_in = a;
        bus.b_in = b;
        bus.start = 1'b1;
        if (mt) begin
            bus.mthi = 1'b1;
            bus.mtlo = 1'b1;
            bus.hi_wdata = 32'h00000BAD;
            bus.lo_wdata = 32'h00000BAD;
        end
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.t0 = cyc + 1;
        e.lat = edz ? 1 : 33;
        q.push_back(e);
        nb = 0;
        fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.start = 1'b0;
                bus.mthi = 1'b0;
                bus.mtlo = 1'b0;
                bus.a_in = 32'h5A5A1234;
                bus.b_in = 32'h0;
            end
            if (bus.busy) nb++;
            if (poke && i == 10) bus.start = 1'b1;
            if (poke && i == 11) bus.start = 1'b0;
            if (q.size() == 0) fin = 1'b1;
        end
        chk("op_completed", {31'b0, fin}, 32'd1);
        chk("busy_cycles", nb, edz ? 32'd1 : 32'd33);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        bus.hi_wdata = '0;
        bus.lo_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'b0, bus.busy}, 32'h0);

        run_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFFFFFA, 32'hFFFFFFF9, 32'h00000000, 32'h0000002A, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.hi_wdata = 32'h11;
        bus.lo_wdata = 32'h22;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mthi", bus.hi, 32'h11);
        chk("mtlo", bus.lo, 32'h22);

        run_op(2'b11, 32'd55, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1);
        chk("dz_hi_kept", bus.hi, 32'h11);
        chk("dz_lo_kept", bus.lo, 32'h22);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        bus.op = 2'b00;
        bus.a_in = 32'd1234;
        bus.b_in = 32'd5678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_done", {31'b0, bus.done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle", {31'b0, bus.busy}, 32'h0);

        run_op(2'b00, 32'd3, 32'd4, 32'h0, 32'h0000000C, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
